// File: rtl/mcycle_issue_ctrl.sv
// mcycle_issue_ctrl: issue/writeback controller for the multi-cycle MUL/DIV unit.
// Accepts one request, drives MCycle Start/Op/Operands, captures the selected
// result and hands it to writeback while stalling the upstream pipeline.
// Optional macro MCYCLE_DIV0_EN: divide-by-zero bypasses MCycle and completes
// locally (Result1 = all ones, Result2 = dividend).
module mcycle_issue_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REGW  = 4
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [1:0]       ReqOp,
   input  logic             ReqSel,
   input  logic [WIDTH-1:0] ReqA,
   input  logic [WIDTH-1:0] ReqB,
   input  logic [REGW-1:0]  ReqRd,
   output logic             McStart,
   output logic [1:0]       McOp,
   output logic [WIDTH-1:0] McOp1,
   output logic [WIDTH-1:0] McOp2,
   input  logic [WIDTH-1:0] McResult1,
   input  logic [WIDTH-1:0] McResult2,
   input  logic             McBusy,
   output logic             WbValid,
   input  logic             WbReady,
   output logic [WIDTH-1:0] WbData,
   output logic [REGW-1:0]  WbRd,
   output logic             Stall
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_op;
   logic             r_sel;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [REGW-1:0]  r_rd;
   logic             r_start;
   logic             r_req_ready;
   logic             r_wb_valid;
   logic [WIDTH-1:0] r_wb_data;
   logic [REGW-1:0]  r_wb_rd;

   logic             w_div0;
   logic             w_idle;
   logic             w_done;

   // Divide-by-zero detection on the incoming request (only when bypass is built in)
`ifdef MCYCLE_DIV0_EN
   assign w_div0 = ReqOp[1] & (ReqB == '0);
`else
   assign w_div0 = 1'b0;
`endif

   // Operation sequencing: accept, issue until Busy seen, wait for Busy low, hand off
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_sel       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_rd        <= '0;
         r_start     <= 1'b0;
         r_req_ready <= 1'b1;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_wb_rd     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  r_op        <= ReqOp;
                  r_sel       <= ReqSel;
                  r_a         <= ReqA;
                  r_b         <= ReqB;
                  r_rd        <= ReqRd;
                  r_req_ready <= 1'b0;
                  if (w_div0) begin
                     r_wb_data  <= ReqSel ? ReqA : '1;
                     r_wb_rd    <= ReqRd;
                     r_wb_valid <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_start <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // Drop Start on the same edge Busy is seen so MCycle cannot restart
               if (McBusy) begin
                  r_start <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!McBusy) begin
                  r_wb_data  <= r_sel ? McResult2 : McResult1;
                  r_wb_rd    <= r_rd;
                  r_wb_valid <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (WbReady) begin
                  r_wb_valid  <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_idle = (r_state == S_IDLE);
   assign w_done = (r_state == S_DONE);

   // Hold upstream from request arrival until the writeback handshake completes
   assign Stall = (w_idle & ReqValid) | (~w_idle & ~(w_done & WbReady));

   assign ReqReady = r_req_ready;
   assign McStart  = r_start;
   assign McOp     = r_op;
   assign McOp1    = r_a;
   assign McOp2    = r_b;
   assign WbValid  = r_wb_valid;
   assign WbData   = r_wb_data;
   assign WbRd     = r_wb_rd;

endmodule
